// File: rtl/minesweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minesweeper_pkg
// Brief    : Cell bit layout, reveal FSM states and neighbour offset tables.
// Revision : 1.0 - initial release
// ============================================================================
package minesweeper_pkg;

    localparam int CELL_COVERED = 5;
    localparam int CELL_FLAG    = 4;
    localparam int CELL_BOMB    = 3;
    localparam int CELL_CNT_MSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ROOT = 3'd1,
        ST_CK_ROOT = 3'd2,
        ST_POP     = 3'd3,
        ST_NB_ADDR = 3'd4,
        ST_NB_CHK  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Offsets are 2-bit codes: NB_MINUS = -1, NB_ZERO = 0, NB_PLUS = +1.
    localparam logic [1:0] NB_MINUS = 2'b11;
    localparam logic [1:0] NB_ZERO  = 2'b00;
    localparam logic [1:0] NB_PLUS  = 2'b01;

    // Packed nb7..nb0, neighbour order NW,N,NE,W,E,SW,S,SE.
    localparam logic [15:0] NB_DCOL = {NB_PLUS, NB_ZERO, NB_MINUS, NB_PLUS,
                                       NB_MINUS, NB_PLUS, NB_ZERO, NB_MINUS};
    localparam logic [15:0] NB_DROW = {NB_PLUS, NB_PLUS, NB_PLUS, NB_ZERO,
                                       NB_ZERO, NB_MINUS, NB_MINUS, NB_MINUS};

    function automatic logic [1:0] nb_dcol(input logic [2:0] nb);
        return NB_DCOL[{nb, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] nb_drow(input logic [2:0] nb);
        return NB_DROW[{nb, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/minesweeper_reveal_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : minesweeper_reveal_engine_if
// Brief    : Reveal request/status and board RAM bus of the reveal engine.
// Revision : 1.0 - initial release
// ============================================================================
interface minesweeper_reveal_engine_if #(
    parameter int COL_W  = 4,
    parameter int ROW_W  = 4,
    parameter int ADDR_W = 8,
    parameter int CELL_W = 6
);
    logic              start;
    logic [COL_W-1:0]  start_col;
    logic [ROW_W-1:0]  start_row;
    logic              busy;
    logic              done;
    logic              hit_bomb;
    logic              overflow;
    logic [ADDR_W:0]   revealed_count;
    logic [ADDR_W-1:0] mem_addr;
    logic [CELL_W-1:0] mem_rdata;
    logic [CELL_W-1:0] mem_wdata;
    logic              mem_we;

    // Environment side: game hub plus board RAM.
    modport master (
        output start, start_col, start_row, mem_rdata,
        input  busy, done, hit_bomb, overflow, revealed_count,
        input  mem_addr, mem_wdata, mem_we
    );

    // Engine side.
    modport slave (
        input  start, start_col, start_row, mem_rdata,
        output busy, done, hit_bomb, overflow, revealed_count,
        output mem_addr, mem_wdata, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/reveal_fifo.sv
`default_nettype none
// ============================================================================
// Module   : reveal_fifo
// Brief    : Show-ahead synchronous FIFO holding BFS frontier coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module reveal_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_pop_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_pop_data = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin : p_ptr
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : p_mem
        if (i_push && !o_full) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/minesweeper_reveal_engine.sv
`default_nettype none
// ============================================================================
// Module   : minesweeper_reveal_engine
// Brief    : BFS flood-fill reveal of a W x H board held in single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module minesweeper_reveal_engine
    import minesweeper_pkg::*;
#(
    parameter int BOARD_W     = 16,
    parameter int BOARD_H     = 16,
    parameter int QUEUE_DEPTH = 64,
    parameter int CELL_W      = 6,
    parameter int ADDR_W      = $clog2(BOARD_W * BOARD_H),
    parameter int COL_W       = $clog2(BOARD_W),
    parameter int ROW_W       = $clog2(BOARD_H)
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    minesweeper_reveal_engine_if.slave bus
);
    localparam logic [COL_W-1:0] c_last_col = COL_W'(BOARD_W - 1);
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(BOARD_H - 1);

    state_t r_state, w_next;

    logic [COL_W-1:0]       r_root_col, r_cen_col, w_nb_col;
    logic [ROW_W-1:0]       r_root_row, r_cen_row, w_nb_row;
    logic [2:0]             r_nb;
    logic                   r_hit_bomb, r_overflow;
    logic [ADDR_W:0]        r_count;
    logic [1:0]             w_dcol, w_drow;
    logic                   w_nb_inb, w_nb_step;
    logic [ADDR_W-1:0]      w_root_addr, w_nb_addr, w_mem_addr;
    logic                   w_mem_we, w_set_hit, w_count_inc;
    logic                   w_covered, w_flagged, w_bomb, w_zero;
    logic [CELL_W-1:0]      w_wdata;
    logic                   w_push, w_pop, w_full, w_empty;
    logic [ROW_W+COL_W-1:0] w_push_data, w_pop_data;

    reveal_fifo #(
        .WIDTH (ROW_W + COL_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Neighbour coordinates with edge compares instead of signed arithmetic.
    always_comb begin : p_nb
        w_dcol   = nb_dcol(r_nb);
        w_drow   = nb_drow(r_nb);
        w_nb_inb = 1'b1;
        w_nb_col = r_cen_col;
        w_nb_row = r_cen_row;
        if (w_dcol == NB_MINUS) begin
            if (r_cen_col == '0) w_nb_inb = 1'b0;
            else                 w_nb_col = r_cen_col - 1'b1;
        end else if (w_dcol == NB_PLUS) begin
            if (r_cen_col == c_last_col) w_nb_inb = 1'b0;
            else                         w_nb_col = r_cen_col + 1'b1;
        end
        if (w_drow == NB_MINUS) begin
            if (r_cen_row == '0) w_nb_inb = 1'b0;
            else                 w_nb_row = r_cen_row - 1'b1;
        end else if (w_drow == NB_PLUS) begin
            if (r_cen_row == c_last_row) w_nb_inb = 1'b0;
            else                         w_nb_row = r_cen_row + 1'b1;
        end
    end

    assign w_root_addr = ADDR_W'(r_root_row) * ADDR_W'(BOARD_W) + ADDR_W'(r_root_col);
    assign w_nb_addr   = ADDR_W'(w_nb_row) * ADDR_W'(BOARD_W) + ADDR_W'(w_nb_col);

    assign w_covered = bus.mem_rdata[CELL_COVERED];
    assign w_flagged = bus.mem_rdata[CELL_FLAG];
    assign w_bomb    = bus.mem_rdata[CELL_BOMB];
    assign w_zero    = (bus.mem_rdata[CELL_CNT_MSB:0] == '0);

    always_comb begin : p_wdata
        w_wdata               = bus.mem_rdata;
        w_wdata[CELL_COVERED] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin : p_state
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin : p_fsm
        w_next      = r_state;
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_set_hit   = 1'b0;
        w_count_inc = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_nb_step   = 1'b0;
        w_push_data = {r_root_row, r_root_col};
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_RD_ROOT;
            end
            ST_RD_ROOT: begin
                w_mem_addr = w_root_addr;
                w_next     = ST_CK_ROOT;
            end
            ST_CK_ROOT: begin
                w_mem_addr = w_root_addr;
                w_next     = ST_DONE;
                if (w_covered && !w_flagged) begin
                    w_mem_we = 1'b1;
                    if (w_bomb) begin
                        w_set_hit = 1'b1;
                    end else begin
                        w_count_inc = 1'b1;
                        if (w_zero) begin
                            w_push = 1'b1;
                            w_next = ST_POP;
                        end
                    end
                end
            end
            ST_POP: begin
                if (w_empty) begin
                    w_next = ST_DONE;
                end else begin
                    w_pop  = 1'b1;
                    w_next = ST_NB_ADDR;
                end
            end
            ST_NB_ADDR: begin
                if (w_nb_inb) begin
                    w_mem_addr = w_nb_addr;
                    w_next     = ST_NB_CHK;
                end else if (r_nb == 3'd7) begin
                    w_next = ST_POP;
                end else begin
                    w_nb_step = 1'b1;
                end
            end
            ST_NB_CHK: begin
                w_mem_addr  = w_nb_addr;
                w_push_data = {w_nb_row, w_nb_col};
                if (w_covered && !w_flagged && !w_bomb) begin
                    w_mem_we    = 1'b1;
                    w_count_inc = 1'b1;
                    w_push      = w_zero;
                end
                if (r_nb == 3'd7) begin
                    w_next = ST_POP;
                end else begin
                    w_nb_step = 1'b1;
                    w_next    = ST_NB_ADDR;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin : p_data
        if (!reset) begin
            r_root_col <= '0;
            r_root_row <= '0;
            r_cen_col  <= '0;
            r_cen_row  <= '0;
            r_nb       <= '0;
            r_hit_bomb <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else begin
            if (r_state == ST_IDLE && bus.start) begin
                r_root_col <= bus.start_col;
                r_root_row <= bus.start_row;
                r_hit_bomb <= 1'b0;
                r_overflow <= 1'b0;
                r_count    <= '0;
            end
            if (w_set_hit) r_hit_bomb <= 1'b1;
            if (w_count_inc && r_count != '1) r_count <= r_count + 1'b1;
            // A dropped push still leaves the cell revealed; only expansion is lost.
            if (w_push && w_full) r_overflow <= 1'b1;
            if (w_pop) begin
                {r_cen_row, r_cen_col} <= w_pop_data;
                r_nb                   <= '0;
            end else if (w_nb_step) begin
                r_nb <= r_nb + 1'b1;
            end
        end
    end

    assign bus.busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.done           = (r_state == ST_DONE);
    assign bus.hit_bomb       = r_hit_bomb;
    assign bus.overflow       = r_overflow;
    assign bus.revealed_count = r_count;
    assign bus.mem_addr       = w_mem_addr;
    assign bus.mem_wdata      = w_wdata;
    assign bus.mem_we         = w_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_minesweeper_reveal_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_minesweeper_reveal_engine
// Brief    : Self-checking bench: vector table, corner sequences, random boards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minesweeper_reveal_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // a: 4x4 main board, b: 8x8 with a tiny queue, c: 16x16 default size.
    minesweeper_reveal_engine_if #(.COL_W(2), .ROW_W(2), .ADDR_W(4), .CELL_W(6)) if_a ();
    minesweeper_reveal_engine_if #(.COL_W(3), .ROW_W(3), .ADDR_W(6), .CELL_W(6)) if_b ();
    minesweeper_reveal_engine_if #(.COL_W(4), .ROW_W(4), .ADDR_W(8), .CELL_W(6)) if_c ();

    minesweeper_reveal_engine #(.BOARD_W(4), .BOARD_H(4), .QUEUE_DEPTH(16)) u_a (
        .clk(clk), .reset(reset), .bus(if_a));
    minesweeper_reveal_engine #(.BOARD_W(8), .BOARD_H(8), .QUEUE_DEPTH(2)) u_b (
        .clk(clk), .reset(reset), .bus(if_b));
    minesweeper_reveal_engine #(.BOARD_W(16), .BOARD_H(16), .QUEUE_DEPTH(64)) u_c (
        .clk(clk), .reset(reset), .bus(if_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Board RAMs: registered read, write on mem_we, write bookkeeping.
    logic [5:0] ram_a [16];
    logic [5:0] ram_b [64];
    logic [5:0] ram_c [256];
    bit         wmask_a [16];
    bit         wmask_b [64];
    int         wr_a, wr_b, wr_c, dbl_a, dbl_b;

    always @(posedge clk) begin
        if_a.mem_rdata <= ram_a[if_a.mem_addr];
        if (if_a.mem_we) begin
            if (wmask_a[if_a.mem_addr]) dbl_a++;
            wmask_a[if_a.mem_addr] = 1'b1;
            wr_a++;
            ram_a[if_a.mem_addr] = if_a.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if_b.mem_rdata <= ram_b[if_b.mem_addr];
        if (if_b.mem_we) begin
            if (wmask_b[if_b.mem_addr]) dbl_b++;
            wmask_b[if_b.mem_addr] = 1'b1;
            wr_b++;
            ram_b[if_b.mem_addr] = if_b.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if_c.mem_rdata <= ram_c[if_c.mem_addr];
        if (if_c.mem_we) begin
            wr_c++;
            ram_c[if_c.mem_addr] = if_c.mem_wdata;
        end
    end

    // ---------------- reference model for the 4x4 board ----------------
    logic [5:0] init_a [16];
    logic [5:0] exp_a  [16];

    function automatic bit eligible(input logic [5:0] v);
        return v[5] && !v[4] && !v[3];
    endfunction

    // Revealed set = fixpoint of "eligible cell touching a revealed zero cell".
    task automatic model_a(input int r, input int c, output int cnt, output int hit);
        bit rev [16];
        bit changed;
        int root;
        root = r * 4 + c;
        cnt  = 0;
        hit  = 0;
        for (int i = 0; i < 16; i++) begin
            exp_a[i] = init_a[i];
            rev[i]   = 1'b0;
        end
        if (!init_a[root][5] || init_a[root][4]) return;
        if (init_a[root][3]) begin
            exp_a[root][5] = 1'b0;
            hit = 1;
            return;
        end
        rev[root] = 1'b1;
        changed   = 1'b1;
        while (changed) begin
            changed = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (!rev[i] && eligible(init_a[i])) begin
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            int jr, jc, j;
                            jr = i / 4 + dr;
                            jc = i % 4 + dc;
                            j  = jr * 4 + jc;
                            if ((dr != 0 || dc != 0) && jr >= 0 && jr < 4 && jc >= 0 && jc < 4
                                && rev[j] && init_a[j][2:0] == 3'd0) begin
                                rev[i]  = 1'b1;
                                changed = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (rev[i]) begin
                exp_a[i][5] = 1'b0;
                cnt++;
            end
        end
    endtask

    task automatic fill_a(input int kind);
        for (int i = 0; i < 16; i++) init_a[i] = (kind == 5) ? 6'b100010 : 6'b100000;
        case (kind)
            1: init_a[1 * 4 + 2] = 6'b110000;
            2: init_a[2 * 4 + 1] = 6'b000000;
            3: for (int r = 0; r < 4; r++) begin
                   init_a[r * 4 + 2] = 6'b100001;
                   init_a[r * 4 + 3] = 6'b101000;
               end
            4: init_a[15] = 6'b101011;
            default: ;
        endcase
    endtask

    task automatic load_a();
        for (int i = 0; i < 16; i++) begin
            ram_a[i]   = init_a[i];
            wmask_a[i] = 1'b0;
        end
        wr_a  = 0;
        dbl_a = 0;
    endtask

    task automatic cmp_board_a(input string name);
        int bad;
        bad = -1;
        for (int i = 15; i >= 0; i--) if (ram_a[i] != exp_a[i]) bad = i;
        check(name, bad, -1);
    endtask

    // Issue a start and wait for done; lat counts negedges from the accepting edge.
    task automatic run_a(input int row, input int col, output int lat, output int busy1, output bit ok);
        @(negedge clk);
        if_a.start_row = 2'(row);
        if_a.start_col = 2'(col);
        if_a.start     = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        busy1 = int'(if_a.busy);
        lat   = 1;
        ok    = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (if_a.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        string name;
        int    kind;
        int    row;
        int    col;
        int    exp_cnt;
        int    exp_hit;
        int    exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int  lat, busy1, mcnt, mhit, cyc;
        bit  ok;

        vecs[0] = '{"zero_flood",     0, 0, 0, 16, 0, 0};
        vecs[1] = '{"flag_root",      1, 1, 2,  0, 0, 3};
        vecs[2] = '{"open_root",      2, 2, 1,  0, 0, 3};
        vecs[3] = '{"corner_region",  3, 0, 0, 12, 0, 0};
        vecs[4] = '{"bomb_root_4x4",  4, 3, 3,  0, 1, 3};
        vecs[5] = '{"number_root",    5, 2, 3,  1, 0, 3};
        vecs[6] = '{"zero_flood_mid", 0, 3, 2, 16, 0, 0};

        reset = 1'b0;
        {if_a.start, if_b.start, if_c.start} = '0;
        if_a.start_row = '0; if_a.start_col = '0;
        if_b.start_row = '0; if_b.start_col = '0;
        if_c.start_row = '0; if_c.start_col = '0;
        fill_a(0);
        load_a();
        for (int i = 0; i < 64; i++) ram_b[i] = 6'b100000;
        for (int i = 0; i < 256; i++) ram_c[i] = 6'b100000;
        repeat (3) @(negedge clk);

        check("reset_busy",     int'(if_a.busy), 0);
        check("reset_done",     int'(if_a.done), 0);
        check("reset_hit_bomb", int'(if_a.hit_bomb), 0);
        check("reset_overflow", int'(if_a.overflow), 0);
        check("reset_count",    int'(if_a.revealed_count), 0);
        check("reset_mem_addr", int'(if_a.mem_addr), 0);
        check("reset_mem_we",   int'(if_a.mem_we), 0);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- vector table ----------------
        foreach (vecs[v]) begin
            fill_a(vecs[v].kind);
            load_a();
            model_a(vecs[v].row, vecs[v].col, mcnt, mhit);
            run_a(vecs[v].row, vecs[v].col, lat, busy1, ok);
            check({vecs[v].name, "_done_seen"}, int'(ok), 1);
            check({vecs[v].name, "_busy_after_start"}, busy1, 1);
            check({vecs[v].name, "_busy_at_done"}, int'(if_a.busy), 0);
            check({vecs[v].name, "_count"}, int'(if_a.revealed_count), vecs[v].exp_cnt);
            check({vecs[v].name, "_hit_bomb"}, int'(if_a.hit_bomb), vecs[v].exp_hit);
            check({vecs[v].name, "_overflow"}, int'(if_a.overflow), 0);
            check({vecs[v].name, "_writes"}, wr_a, vecs[v].exp_cnt + vecs[v].exp_hit);
            check({vecs[v].name, "_double_writes"}, dbl_a, 0);
            if (vecs[v].exp_lat != 0) check({vecs[v].name, "_latency"}, lat, vecs[v].exp_lat);
            cmp_board_a({vecs[v].name, "_board_first_bad_idx"});
        end

        // ---------------- start is ignored while busy ----------------
        fill_a(0);
        load_a();
        model_a(0, 0, mcnt, mhit);
        @(negedge clk);
        if_a.start_row = 2'd0; if_a.start_col = 2'd0; if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        repeat (4) @(negedge clk);
        if_a.start_row = 2'd3; if_a.start_col = 2'd3; if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        cyc = 0;
        while (!if_a.done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_ignored_done_seen", int'(cyc < 2000), 1);
        check("restart_ignored_count", int'(if_a.revealed_count), mcnt);
        cmp_board_a("restart_ignored_board_first_bad_idx");

        // ---------------- reset mid-flood ----------------
        fill_a(0);
        load_a();
        @(negedge clk);
        if_a.start_row = 2'd0; if_a.start_col = 2'd0; if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        repeat (6) @(negedge clk);
        check("midflood_busy_before_reset", int'(if_a.busy), 1);
        reset = 1'b0;
        #1;
        check("midflood_busy_in_reset",  int'(if_a.busy), 0);
        check("midflood_we_in_reset",    int'(if_a.mem_we), 0);
        check("midflood_count_in_reset", int'(if_a.revealed_count), 0);
        check("midflood_fifo_empty",     int'(u_a.u_fifo.o_empty), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_reset_busy", int'(if_a.busy), 0);
        fill_a(0);
        load_a();
        model_a(0, 0, mcnt, mhit);
        run_a(0, 0, lat, busy1, ok);
        check("after_reset_done_seen", int'(ok), 1);
        check("after_reset_count", int'(if_a.revealed_count), 16);
        cmp_board_a("after_reset_board_first_bad_idx");

        // ---------------- 16x16 bomb root ----------------
        ram_c[5 * 16 + 5] = 6'b101011;
        wr_c = 0;
        @(negedge clk);
        if_c.start_row = 4'd5; if_c.start_col = 4'd5; if_c.start = 1'b1;
        @(negedge clk);
        if_c.start = 1'b0;
        lat = 1;
        while (!if_c.done && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("bomb16_latency",  lat, 3);
        check("bomb16_hit_bomb", int'(if_c.hit_bomb), 1);
        check("bomb16_writes",   wr_c, 1);
        check("bomb16_count",    int'(if_c.revealed_count), 0);
        check("bomb16_cell",     int'(ram_c[85]), int'(6'b001011));
        check("bomb16_neighbour_untouched", int'(ram_c[84]), int'(6'b100000));

        // ---------------- tiny queue overflow on 8x8 ----------------
        for (int i = 0; i < 64; i++) begin
            ram_b[i]   = 6'b100000;
            wmask_b[i] = 1'b0;
        end
        wr_b  = 0;
        dbl_b = 0;
        @(negedge clk);
        if_b.start_row = 3'd3; if_b.start_col = 3'd3; if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        cyc = 0;
        while (!if_b.done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        begin
            int open_cells;
            open_cells = 0;
            for (int i = 0; i < 64; i++) if (!ram_b[i][5]) open_cells++;
            check("ovf_done_seen",        int'(cyc < 5000), 1);
            check("ovf_overflow",         int'(if_b.overflow), 1);
            check("ovf_hit_bomb",         int'(if_b.hit_bomb), 0);
            check("ovf_double_writes",    dbl_b, 0);
            check("ovf_count_vs_writes",  int'(if_b.revealed_count), wr_b);
            check("ovf_count_vs_board",   int'(if_b.revealed_count), open_cells);
            check("ovf_root_ring_opened", int'(if_b.revealed_count >= 9), 1);
        end
        // Root is now uncovered: no write, and the sticky flag clears.
        wr_b = 0;
        @(negedge clk);
        if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        lat = 1;
        while (!if_b.done && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("ovf_clear_latency",  lat, 3);
        check("ovf_clear_overflow", int'(if_b.overflow), 0);
        check("ovf_clear_count",    int'(if_b.revealed_count), 0);
        check("ovf_clear_writes",   wr_b, 0);

        // ---------------- randomized boards vs model ----------------
        for (int it = 0; it < 40; it++) begin
            int r, c;
            for (int i = 0; i < 16; i++) begin
                int unsigned v;
                bit cov, flg, bmb;
                int cnt;
                v   = $urandom;
                cov = (v % 8) != 0;
                flg = ((v >> 3) % 16) == 0;
                bmb = ((v >> 7) % 8) == 0;
                cnt = ((v >> 10) % 2 == 1) ? 0 : int'(1 + (v >> 11) % 7);
                init_a[i] = {cov, flg, bmb, 3'(cnt)};
            end
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            load_a();
            model_a(r, c, mcnt, mhit);
            run_a(r, c, lat, busy1, ok);
            check($sformatf("rand%0d_done_seen", it), int'(ok), 1);
            check($sformatf("rand%0d_count", it), int'(if_a.revealed_count), mcnt);
            check($sformatf("rand%0d_hit_bomb", it), int'(if_a.hit_bomb), mhit);
            check($sformatf("rand%0d_overflow", it), int'(if_a.overflow), 0);
            check($sformatf("rand%0d_writes", it), wr_a, mcnt + mhit);
            cmp_board_a($sformatf("rand%0d_board_first_bad_idx", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
